// File: rtl/uart_receive.sv
// UART receiver: 2-flop synchroniser, mid-bit sampling, LSB-first deserialise onto a valid/ready port.
// rx_valid rises 3+CLKS_PER_BIT/2 clk after the stop-bit edge; a word arriving while rx_valid is unconsumed is dropped with an overrun pulse.
module uart_receive #(
  parameter int D_WIDTH      = 4,
  parameter int CLKS_PER_BIT = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               rx,
  output logic [D_WIDTH-1:0] rx_data,
  output logic               rx_valid,
  input  logic               rx_ready,
  output logic               rx_busy,
  output logic               frame_err,
  output logic               overrun
);

  localparam int CW   = $clog2(CLKS_PER_BIT + 1);
  localparam int IW   = $clog2(D_WIDTH + 1);
  localparam int HALF = CLKS_PER_BIT / 2;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'((HALF > 0) ? (HALF - 1) : 0);
  localparam logic [IW-1:0] IDX_LAST = IW'(D_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t             state;
  logic               rx_meta;
  logic               rxs;
  logic               armed;
  logic [CW-1:0]      cnt;
  logic [IW-1:0]      idx;
  logic [D_WIDTH-1:0] shreg;
  logic [D_WIDTH:0]   shift_in;

  assign shift_in = {rxs, shreg};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      armed     <= 1'b1;
      cnt       <= '0;
      idx       <= '0;
      shreg     <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      rx_busy   <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      if (rx_valid && rx_ready) rx_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (rxs) begin
            armed <= 1'b1;
          end else if (armed) begin
            cnt     <= '0;
            idx     <= '0;
            rx_busy <= 1'b1;
            // With one-clock bits the detecting sample already is the mid-start sample.
            state   <= (HALF == 0) ? DATA : START;
          end
        end
        START: begin
          if (cnt == CNT_HALF) begin
            cnt <= '0;
            idx <= '0;
            if (rxs) begin
              state   <= IDLE;
              rx_busy <= 1'b0;
            end else begin
              state <= DATA;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == CNT_LAST) begin
            shreg <= shift_in[D_WIDTH:1];
            cnt   <= '0;
            idx   <= idx + 1'b1;
            if (idx == IDX_LAST) state <= STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (cnt == CNT_LAST) begin
            state   <= IDLE;
            rx_busy <= 1'b0;
            cnt     <= '0;
            if (!rxs) begin
              frame_err <= 1'b1;
              armed     <= 1'b0;
            end else if (!rx_valid || rx_ready) begin
              rx_data  <= shreg;
              rx_valid <= 1'b1;
            end else begin
              overrun <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          rx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_receive.sv
// Directed bench for uart_receive: one instance with one-clock bits, one with four-clock bits.
module tb_uart_receive;

  logic       clk;
  logic       rst_n;
  logic       rx1, rx_ready1, rx_valid1, busy1, ferr1, ovr1;
  logic [3:0] rx_data1;
  logic       rx4, rx_ready4, rx_valid4, busy4, ferr4, ovr4;
  logic [3:0] rx_data4;

  int total = 0;
  int bad   = 0;

  int n_xfer1 = 0, n_ferr1 = 0, n_ovr1 = 0, n_busy1 = 0;
  int n_xfer4 = 0, n_ferr4 = 0, n_busy4 = 0;
  logic [3:0] last1 = 4'h0;
  logic [3:0] last4 = 4'h0;

  uart_receive #(.D_WIDTH(4), .CLKS_PER_BIT(1)) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx1), .rx_data(rx_data1), .rx_valid(rx_valid1),
    .rx_ready(rx_ready1), .rx_busy(busy1), .frame_err(ferr1), .overrun(ovr1)
  );

  uart_receive #(.D_WIDTH(4), .CLKS_PER_BIT(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .rx(rx4), .rx_data(rx_data4), .rx_valid(rx_valid4),
    .rx_ready(rx_ready4), .rx_busy(busy4), .frame_err(ferr4), .overrun(ovr4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Event counters sampled mid-cycle; a transfer is valid&ready seen before the next edge.
  always @(negedge clk) begin
    if (rx_valid1 && rx_ready1) begin n_xfer1++; last1 = rx_data1; end
    if (ferr1) n_ferr1++;
    if (ovr1)  n_ovr1++;
    if (busy1) n_busy1++;
    if (rx_valid4 && rx_ready4) begin n_xfer4++; last4 = rx_data4; end
    if (ferr4) n_ferr4++;
    if (busy4) n_busy4++;
  end

  task automatic drive1(input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1 rx1 = bits[i];
    end
  endtask

  task automatic drive4(input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < 4; j++) begin
        @(posedge clk); #1 rx4 = bits[i];
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; rx1 = 1'b1; rx4 = 1'b1; rx_ready1 = 1'b1; rx_ready4 = 1'b1;
    #12;
    total++; if ({rx_data1, rx_valid1, busy1, ferr1, ovr1} !== 8'h00) begin bad++;
      $display("FAIL reset_cpb1 got=%h want=00", {rx_data1, rx_valid1, busy1, ferr1, ovr1}); end
    total++; if ({rx_data4, rx_valid4, busy4, ferr4, ovr4} !== 8'h00) begin bad++;
      $display("FAIL reset_cpb4 got=%h want=00", {rx_data4, rx_valid4, busy4, ferr4, ovr4}); end
    @(negedge clk); rst_n = 1'b1;
    idle(4);
  endtask

  task automatic test_basic_frame;
    int sx = n_xfer1, sf = n_ferr1, so = n_ovr1;
    // idle 1, start 0, data 0,1,0,1 (0xA LSB first), stop 1
    drive1(16'b1101001, 7);
    repeat (2) @(posedge clk); @(negedge clk);
    total++; if (rx_valid1 !== 1'b0) begin bad++; $display("FAIL basic_early got=%b want=0", rx_valid1); end
    @(posedge clk); @(negedge clk);
    total++; if (rx_valid1 !== 1'b1) begin bad++; $display("FAIL basic_latency got=%b want=1", rx_valid1); end
    total++; if (rx_data1 !== 4'hA) begin bad++; $display("FAIL basic_data got=%h want=a", rx_data1); end
    @(posedge clk); @(negedge clk);
    total++; if (rx_valid1 !== 1'b0) begin bad++; $display("FAIL basic_consumed got=%b want=0", rx_valid1); end
    idle(3);
    total++; if (n_xfer1 - sx !== 1) begin bad++; $display("FAIL basic_count got=%0d want=1", n_xfer1 - sx); end
    total++; if ((n_ferr1 - sf) + (n_ovr1 - so) !== 0) begin bad++;
      $display("FAIL basic_flags got=%0d want=0", (n_ferr1 - sf) + (n_ovr1 - so)); end
  endtask

  task automatic test_false_start;
    int sx = n_xfer4, sf = n_ferr4, sb = n_busy4;
    @(posedge clk); #1 rx4 = 1'b0;
    @(posedge clk); #1 rx4 = 1'b1;
    idle(12);
    total++; if (n_busy4 - sb !== 2) begin bad++; $display("FAIL glitch_busy got=%0d want=2", n_busy4 - sb); end
    total++; if (n_xfer4 - sx !== 0) begin bad++; $display("FAIL glitch_valid got=%0d want=0", n_xfer4 - sx); end
    total++; if (n_ferr4 - sf !== 0) begin bad++; $display("FAIL glitch_ferr got=%0d want=0", n_ferr4 - sf); end
  endtask

  task automatic test_cpb4_frame;
    int sx = n_xfer4;
    drive4({10'b0, 6'b101100}, 6);  // stop 1, data 0x6, start 0
    @(posedge clk); @(negedge clk);
    total++; if (rx_valid4 !== 1'b0) begin bad++; $display("FAIL cpb4_early got=%b want=0", rx_valid4); end
    @(posedge clk); @(negedge clk);
    total++; if (rx_valid4 !== 1'b1) begin bad++; $display("FAIL cpb4_latency got=%b want=1", rx_valid4); end
    total++; if (rx_data4 !== 4'h6) begin bad++; $display("FAIL cpb4_data got=%h want=6", rx_data4); end
    idle(4);
    total++; if (n_xfer4 - sx !== 1) begin bad++; $display("FAIL cpb4_count got=%0d want=1", n_xfer4 - sx); end
  endtask

  task automatic test_frame_error;
    int sx = n_xfer1, sf = n_ferr1, sb;
    drive1({10'b0, 6'b001010}, 6);  // stop 0, data 0x5, start 0; line then stays low
    idle(4);
    total++; if (n_ferr1 - sf !== 1) begin bad++; $display("FAIL ferr_pulse got=%0d want=1", n_ferr1 - sf); end
    total++; if (n_xfer1 - sx !== 0) begin bad++; $display("FAIL ferr_novalid got=%0d want=0", n_xfer1 - sx); end
    sb = n_busy1;
    idle(20);
    total++; if (n_busy1 - sb !== 0) begin bad++; $display("FAIL break_busy got=%0d want=0", n_busy1 - sb); end
    rx1 = 1'b1;
    idle(5);
  endtask

  task automatic test_overrun;
    int sx = n_xfer1, so = n_ovr1;
    rx_ready1 = 1'b0;
    drive1({4'b0, 6'b111000, 6'b100110}, 12);  // 0x3 then 0xC, no gap
    idle(4);
    total++; if (rx_valid1 !== 1'b1) begin bad++; $display("FAIL ovr_valid got=%b want=1", rx_valid1); end
    total++; if (rx_data1 !== 4'h3) begin bad++; $display("FAIL ovr_held got=%h want=3", rx_data1); end
    total++; if (n_ovr1 - so !== 1) begin bad++; $display("FAIL ovr_pulse got=%0d want=1", n_ovr1 - so); end
    rx_ready1 = 1'b1;
    @(posedge clk); @(negedge clk);
    total++; if (rx_valid1 !== 1'b0) begin bad++; $display("FAIL ovr_drain got=%b want=0", rx_valid1); end
    total++; if (n_xfer1 - sx !== 1 || last1 !== 4'h3) begin bad++;
      $display("FAIL ovr_xfer got=%0d/%h want=1/3", n_xfer1 - sx, last1); end
    idle(2);
  endtask

  task automatic test_back_to_back;
    int sx = n_xfer1, so = n_ovr1;
    rx_ready1 = 1'b0;
    drive1({4'b0, 6'b111000, 6'b100110}, 12);
    idle(2);
    total++; if (rx_valid1 !== 1'b1 || rx_data1 !== 4'h3) begin bad++;
      $display("FAIL b2b_first got=%b/%h want=1/3", rx_valid1, rx_data1); end
    rx_ready1 = 1'b1;  // lands exactly on the second stop sample
    @(posedge clk); @(negedge clk);
    total++; if (rx_valid1 !== 1'b1 || rx_data1 !== 4'hC) begin bad++;
      $display("FAIL b2b_swap got=%b/%h want=1/c", rx_valid1, rx_data1); end
    total++; if (n_ovr1 - so !== 0) begin bad++; $display("FAIL b2b_ovr got=%0d want=0", n_ovr1 - so); end
    @(posedge clk); @(negedge clk);
    total++; if (rx_valid1 !== 1'b0) begin bad++; $display("FAIL b2b_drain got=%b want=0", rx_valid1); end
    total++; if (n_xfer1 - sx !== 2 || last1 !== 4'hC) begin bad++;
      $display("FAIL b2b_xfer got=%0d/%h want=2/c", n_xfer1 - sx, last1); end
    idle(2);
  endtask

  task automatic test_reset_mid_frame;
    int sx, sf;
    rx_ready1 = 1'b0;
    drive1({10'b0, 6'b110010}, 6);  // 0x9 left pending
    idle(5);
    total++; if (rx_valid1 !== 1'b1 || rx_data1 !== 4'h9) begin bad++;
      $display("FAIL pre_reset got=%b/%h want=1/9", rx_valid1, rx_data1); end
    drive1(16'b110, 3);  // start, d0=1, d1=1
    idle(3);             // two data samples taken: idx=2
    total++; if (busy1 !== 1'b1) begin bad++; $display("FAIL mid_busy got=%b want=1", busy1); end
    rst_n = 1'b0;
    #1;
    total++; if ({rx_data1, rx_valid1, busy1, ferr1, ovr1} !== 8'h00) begin bad++;
      $display("FAIL mid_reset got=%h want=00", {rx_data1, rx_valid1, busy1, ferr1, ovr1}); end
    @(negedge clk); rst_n = 1'b1;
    rx_ready1 = 1'b1;
    idle(3);
    sx = n_xfer1; sf = n_ferr1;
    drive1({10'b0, 6'b111110}, 6);  // 0xF
    idle(6);
    total++; if (n_xfer1 - sx !== 1 || last1 !== 4'hF) begin bad++;
      $display("FAIL post_reset got=%0d/%h want=1/f", n_xfer1 - sx, last1); end
    total++; if (n_ferr1 - sf !== 0) begin bad++; $display("FAIL post_reset_ferr got=%0d want=0", n_ferr1 - sf); end
  endtask

  initial begin
    test_reset;
    test_basic_frame;
    test_false_start;
    test_cpb4_frame;
    test_frame_error;
    test_overrun;
    test_back_to_back;
    test_reset_mid_frame;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
